// File: rtl/elevator_scheduler.sv
// Call latching, SCAN direction preference and age-bounded starvation override
// for a 3-floor elevator; all outputs are registered.
`timescale 1ns/1ps
module elevator_scheduler #(
    parameter int AGE_W     = 4,
    parameter int AGE_LIMIT = 12
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       u1,
    input  logic       u2,
    input  logic       d2,
    input  logic       d3,
    input  logic       f1,
    input  logic       f2,
    input  logic       f3,
    input  logic [1:0] fs,
    input  logic       door,
    input  logic [1:0] dir,
    output logic [6:0] lamps,
    output logic [1:0] pref,
    output logic [1:0] req_dir,
    output logic       req_open,
    output logic [1:0] target
);
    typedef enum logic [1:0] {
        P_IDLE = 2'b00,
        P_UP   = 2'b01,
        P_DOWN = 2'b10
    } pref_t;

    localparam logic [AGE_W-1:0] AGE_MAX = AGE_W'(AGE_LIMIT);

    pref_t            pref_q, pref_nx;
    logic [6:0]       lamps_q, lamps_nx, btn, serve_mask, clr;
    logic [AGE_W-1:0] age_q [7];
    logic [6:0]       starve_vec;
    logic [1:0]       last_floor, cur_floor, starve_floor;
    logic [1:0]       req_dir_nx, target_nx;
    logic             stopped, open_c, fl1, fl2, fl3, above, below, starved;

    assign btn = {f3, f2, f1, d3, d2, u2, u1};

    always_comb begin
        stopped   = (dir == 2'b00) && (fs != 2'b00);
        cur_floor = (fs != 2'b00) ? fs : last_floor;

        // Calls a stop at fs may clear, given the current direction preference.
        serve_mask = 7'b0;
        case (fs)
            2'b01: serve_mask = 7'b0010001;
            2'b10: begin
                serve_mask[5] = 1'b1;
                serve_mask[1] = (pref_q == P_UP)   || (pref_q == P_IDLE);
                serve_mask[2] = (pref_q == P_DOWN) || (pref_q == P_IDLE);
            end
            2'b11: serve_mask = 7'b1001000;
            default: serve_mask = 7'b0;
        endcase

        clr      = (stopped && !door) ? serve_mask : 7'b0;
        lamps_nx = (lamps_q | btn) & ~clr;
        open_c   = stopped && door && ((lamps_q & serve_mask) != 7'b0);

        fl1 = lamps_q[0] | lamps_q[4];
        fl2 = lamps_q[1] | lamps_q[2] | lamps_q[5];
        fl3 = lamps_q[3] | lamps_q[6];
        above = 1'b0;
        below = 1'b0;
        case (fs)
            2'b01: above = fl2 | fl3;
            2'b10: begin above = fl3; below = fl1; end
            2'b11: below = fl1 | fl2;
            default: ;
        endcase

        // Lowest lamp index wins among starved calls.
        starved      = (starve_vec != 7'b0);
        starve_floor = 2'b00;
        if      (starve_vec[0]) starve_floor = 2'b01;
        else if (starve_vec[1]) starve_floor = 2'b10;
        else if (starve_vec[2]) starve_floor = 2'b10;
        else if (starve_vec[3]) starve_floor = 2'b11;
        else if (starve_vec[4]) starve_floor = 2'b01;
        else if (starve_vec[5]) starve_floor = 2'b10;
        else if (starve_vec[6]) starve_floor = 2'b11;

        pref_nx = pref_q;
        if (stopped) begin
            if (starved) begin
                if (starve_floor > fs)      pref_nx = P_UP;
                else if (starve_floor < fs) pref_nx = P_DOWN;
                else                        pref_nx = P_IDLE;
            end else begin
                case (pref_q)
                    P_DOWN:  pref_nx = below ? P_DOWN : (above ? P_UP : P_IDLE);
                    default: pref_nx = above ? P_UP : (below ? P_DOWN : P_IDLE);
                endcase
            end
        end

        if (stopped && door && !open_c)         req_dir_nx = pref_nx;
        else if (dir == 2'b01 || dir == 2'b10)  req_dir_nx = dir;
        else                                    req_dir_nx = 2'b00;

        target_nx = 2'b00;
        if (pref_nx == P_UP) begin
            if (cur_floor == 2'b01)      target_nx = fl2 ? 2'b10 : (fl3 ? 2'b11 : 2'b00);
            else if (cur_floor == 2'b10) target_nx = fl3 ? 2'b11 : 2'b00;
        end else if (pref_nx == P_DOWN) begin
            if (cur_floor == 2'b11)      target_nx = fl2 ? 2'b10 : (fl1 ? 2'b01 : 2'b00);
            else if (cur_floor == 2'b10) target_nx = fl1 ? 2'b01 : 2'b00;
        end
    end

    for (genvar g = 0; g < 7; g++) begin : g_age
        assign starve_vec[g] = (age_q[g] == AGE_MAX);
        always_ff @(posedge clk or posedge rst) begin
            if (rst)
                age_q[g] <= '0;
            else if (!lamps_nx[g])
                age_q[g] <= '0;
            else if (lamps_q[g] && age_q[g] != AGE_MAX)
                age_q[g] <= age_q[g] + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lamps_q    <= 7'b0;
            pref_q     <= P_IDLE;
            req_dir    <= 2'b00;
            req_open   <= 1'b0;
            target     <= 2'b00;
            last_floor <= 2'b01;
        end else begin
            lamps_q    <= lamps_nx;
            pref_q     <= pref_nx;
            req_dir    <= open_c ? 2'b00 : req_dir_nx;
            req_open   <= open_c;
            target     <= target_nx;
            last_floor <= cur_floor;
        end
    end

    assign lamps = lamps_q;
    assign pref  = pref_q;
endmodule

// File: tb/tb_elevator_scheduler.sv
// Directed bench for elevator_scheduler: call latching, service clears,
// SCAN preference, target selection, aging override and async reset.
`timescale 1ns/1ps
module tb_elevator_scheduler;
    logic       clk = 1'b0;
    logic       rst;
    logic       u1, u2, d2, d3, f1, f2, f3;
    logic [1:0] fs, dir;
    logic       door;
    logic [6:0] lamps;
    logic [1:0] pref, req_dir, target;
    logic       req_open;

    int n_checks = 0;
    int n_fail   = 0;

    elevator_scheduler #(.AGE_W(4), .AGE_LIMIT(12)) dut (
        .clk(clk), .rst(rst),
        .u1(u1), .u2(u2), .d2(d2), .d3(d3),
        .f1(f1), .f2(f2), .f3(f3),
        .fs(fs), .door(door), .dir(dir),
        .lamps(lamps), .pref(pref), .req_dir(req_dir),
        .req_open(req_open), .target(target)
    );

    // clock / reset
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    // driver tasks
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_pos(input logic [1:0] f, input logic [1:0] d, input logic dr);
        fs   = f;
        dir  = d;
        door = dr;
    endtask

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_lamps"},    {1'b0, lamps},    8'h00);
        check({tag, "_pref"},     {6'b0, pref},     8'h00);
        check({tag, "_req_dir"},  {6'b0, req_dir},  8'h00);
        check({tag, "_req_open"}, {7'b0, req_open}, 8'h00);
        check({tag, "_target"},   {6'b0, target},   8'h00);
    endtask

    initial begin
        rst = 1'b1;
        {u1, u2, d2, d3, f1, f2, f3} = 7'b0;
        set_pos(2'b01, 2'b00, 1'b1);
        #12;
        check_all_zero("reset");
        @(negedge clk);
        rst = 1'b0;

        // hall call at current floor: latch, open request, clear on open doors
        u1 = 1'b1;
        tick();
        check("t1_lamp_set", {1'b0, lamps}, 8'h01);
        tick();
        u1 = 1'b0;
        check("t1_req_open", {7'b0, req_open}, 8'h01);
        check("t1_req_dir",  {6'b0, req_dir},  8'h00);
        door = 1'b0;
        tick();
        check("t1_cleared",  {1'b0, lamps},    8'h00);
        check("t1_open_off", {7'b0, req_open}, 8'h00);

        // car call above: preference up, target floor 3, moving holds state
        f3 = 1'b1;
        tick();
        f3 = 1'b0;
        check("t2_lamp_f3", {1'b0, lamps}, 8'h40);
        door = 1'b1;
        tick();
        check("t2_pref",    {6'b0, pref},    8'h01);
        check("t2_req_dir", {6'b0, req_dir}, 8'h01);
        check("t2_target",  {6'b0, target},  8'h03);
        set_pos(2'b00, 2'b01, 1'b1);
        tick();
        check("t2_move_dir",    {6'b0, req_dir}, 8'h01);
        check("t2_move_lamps",  {1'b0, lamps},   8'h40);
        check("t2_move_target", {6'b0, target},  8'h03);

        // floor 2 going up: down call must survive the open doors
        set_pos(2'b10, 2'b00, 1'b1);
        d2 = 1'b1;
        tick();
        d2 = 1'b0;
        check("t3_lamps_set", {1'b0, lamps}, 8'h44);
        door = 1'b0;
        tick();
        tick();
        check("t3_d2_kept", {1'b0, lamps}, 8'h44);
        check("t3_pref_up", {6'b0, pref},  8'h01);
        set_pos(2'b00, 2'b01, 1'b1);
        tick();
        set_pos(2'b11, 2'b00, 1'b1);
        tick();
        check("t3_f3_open",   {7'b0, req_open}, 8'h01);
        check("t3_f3_dir",    {6'b0, req_dir},  8'h00);
        check("t3_pref_down", {6'b0, pref},     8'h02);
        check("t3_target_2",  {6'b0, target},   8'h02);
        door = 1'b0;
        tick();
        check("t3_f3_clear", {1'b0, lamps}, 8'h04);
        set_pos(2'b00, 2'b10, 1'b1);
        tick();
        set_pos(2'b10, 2'b00, 1'b0);
        tick();
        check("t3_d2_clear", {1'b0, lamps}, 8'h00);
        check("t3_pref_idle", {6'b0, pref}, 8'h00);

        // button held while its floor is served with doors open
        f2 = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("t4_f2_blocked", {1'b0, lamps}, 8'h00);
        end
        f2 = 1'b0;

        // asynchronous reset while moving
        set_pos(2'b00, 2'b01, 1'b1);
        f2 = 1'b1;
        d2 = 1'b1;
        tick();
        f2 = 1'b0;
        d2 = 1'b0;
        check("t5_lamps", {1'b0, lamps}, 8'h24);
        check("t5_dir",   {6'b0, req_dir}, 8'h01);
        #2;
        rst = 1'b1;
        #1;
        check_all_zero("t5_async");
        @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        check_all_zero("t5_release");
        set_pos(2'b01, 2'b00, 1'b1);
        tick();
        check("t5_post_lamps", {1'b0, lamps},   8'h00);
        check("t5_post_dir",   {6'b0, req_dir}, 8'h00);

        // aging: u1 and f3 together at floor 2, UP wins until both starve
        rst = 1'b1;
        #2;
        rst = 1'b0;
        set_pos(2'b10, 2'b00, 1'b1);
        u1 = 1'b1;
        f3 = 1'b1;
        tick();
        u1 = 1'b0;
        f3 = 1'b0;
        check("t6_lamps", {1'b0, lamps}, 8'h41);
        check("t6_pref0", {6'b0, pref},  8'h00);
        tick();
        check("t6_pref_up",   {6'b0, pref},    8'h01);
        check("t6_dir_up",    {6'b0, req_dir}, 8'h01);
        check("t6_target_up", {6'b0, target},  8'h03);
        repeat (11) tick();
        check("t6_not_starved", {6'b0, pref}, 8'h01);
        tick();
        check("t6_forced_pref",   {6'b0, pref},    8'h02);
        check("t6_forced_dir",    {6'b0, req_dir}, 8'h02);
        check("t6_forced_target", {6'b0, target},  8'h01);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
